// File: rtl/arm_rf_pkg.sv
// ============================================================================
// Module : arm_rf_pkg
// Shared types and default widths for the ARM register file slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arm_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

endpackage

`default_nettype wire

// File: rtl/arm_regfile_sb_busy.sv
// ============================================================================
// Module : rf_busy_tracker
// Per-register busy scoreboard with set-over-clear priority and read lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_busy_tracker #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    parameter int IDX_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     clr_en_i,
    input  logic [ADDR_W-1:0]        clr_addr_i,
    input  logic                     sclr_en_i,
    input  logic [IDX_W-1:0]         sclr_idx_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    input  logic [NUM_RD-1:0]        rd_mask_i,
    output logic [NUM_RD-1:0]        rd_busy_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [DEPTH-1:0]    busy_view;

    // Soft clear dominates; a new producer outranks a retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (sclr_en_i && (sclr_idx_i == IDX_W'(r))) begin
                busy_d[r] = 1'b0;
            end else if (set_en_i && (set_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (clr_en_i && (clr_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_view
        if (r < NUM_REGS) begin : g_impl
            assign busy_view[r] = busy_q[r];
        end else begin : g_pad
            assign busy_view[r] = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_busy_o[i] = busy_view[rd_addr_i[i*ADDR_W +: ADDR_W]] & ~rd_mask_i[i];
    end

endmodule

`default_nettype wire

// File: rtl/arm_regfile_sb.sv
// ============================================================================
// Module : arm_regfile_sb
// ARM register file: NUM_RD combinational reads, one write-back, optional
// write-to-read bypass, busy scoreboard and sequenced soft-clear engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arm_regfile_sb
    import arm_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     clr_req_i,
    output logic                     ready_o,
    output logic                     clr_done_o
);
    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e          state_q;
    rf_state_e          state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               clearing;

    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  rf_view [DEPTH];
    logic [DEPTH-1:0]   addr_valid;
    logic               wb_live;
    logic               iss_live;
    logic [NUM_RD-1:0]  byp_hit;

    assign wb_live  = wb_en_i  & ready_o & addr_valid[wb_addr_i];
    assign iss_live = iss_en_i & ready_o & addr_valid[iss_addr_i];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ready_o    = 1'b0;
        clr_done_o = 1'b0;
        clearing   = 1'b0;
        case (state_q)
            RF_IDLE: begin
                ready_o = 1'b1;
                if (clr_req_i) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                clearing = 1'b1;
                if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d = RF_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RF_DONE: begin
                clr_done_o = 1'b1;
                state_d    = RF_IDLE;
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (clearing && (idx_q == IDX_W'(r))) begin
                    regs_q[r] <= '0;
                end else if (wb_live && (wb_addr_i == ADDR_W'(r))) begin
                    regs_q[r] <= wb_data_i;
                end
            end
        end
    end

    // Full address space view: unimplemented registers read as zero.
    for (genvar r = 0; r < DEPTH; r++) begin : g_view
        if (r < NUM_REGS) begin : g_impl
            assign rf_view[r]    = regs_q[r];
            assign addr_valid[r] = 1'b1;
        end else begin : g_pad
            assign rf_view[r]    = '0;
            assign addr_valid[r] = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        assign rd_a = rd_addr_i[i*ADDR_W +: ADDR_W];
        if (BYPASS != 0) begin : g_byp
            assign byp_hit[i] = wb_live & (wb_addr_i == rd_a);
        end else begin : g_nobyp
            assign byp_hit[i] = 1'b0;
        end
        assign rd_data_o[i*DATA_W +: DATA_W] = byp_hit[i] ? wb_data_i : rf_view[rd_a];
    end

    rf_busy_tracker #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .IDX_W    (IDX_W)
    ) u_busy (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (iss_live),
        .set_addr_i (iss_addr_i),
        .clr_en_i   (wb_live),
        .clr_addr_i (wb_addr_i),
        .sclr_en_i  (clearing),
        .sclr_idx_i (idx_q),
        .rd_addr_i  (rd_addr_i),
        .rd_mask_i  (byp_hit),
        .rd_busy_o  (rd_busy_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_arm_regfile_sb.sv
// ============================================================================
// Module : tb_arm_regfile_sb
// Directed bench for arm_regfile_sb (default build and a 12-reg/4-port/no-bypass build).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_arm_regfile_sb;

    logic clk;
    logic rst;

    logic [11:0]  rd_addr;
    logic [95:0]  rd_data;
    logic [2:0]   rd_busy;
    logic         wb_en, iss_en, clr_req, ready, clr_done;
    logic [3:0]   wb_addr, iss_addr;
    logic [31:0]  wb_data;

    logic [15:0]  nb_rd_addr;
    logic [127:0] nb_rd_data;
    logic [3:0]   nb_rd_busy;
    logic         nb_wb_en, nb_iss_en, nb_clr_req, nb_ready, nb_clr_done;
    logic [3:0]   nb_wb_addr, nb_iss_addr;
    logic [31:0]  nb_wb_data;

    int n_checks;
    int n_fail;

    arm_regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr),
        .clr_req_i(clr_req), .ready_o(ready), .clr_done_o(clr_done)
    );

    arm_regfile_sb #(.NUM_REGS(12), .NUM_RD(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr_i(nb_rd_addr), .rd_data_o(nb_rd_data), .rd_busy_o(nb_rd_busy),
        .wb_en_i(nb_wb_en), .wb_addr_i(nb_wb_addr), .wb_data_i(nb_wb_data),
        .iss_en_i(nb_iss_en), .iss_addr_i(nb_iss_addr),
        .clr_req_i(nb_clr_req), .ready_o(nb_ready), .clr_done_o(nb_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic        iss_en;
        logic [3:0]  iss_addr;
        logic [11:0] rd_addr;
        logic [95:0] exp_data;
        logic [2:0]  exp_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            wb_en = 1'b1; wb_addr = 4'(i); wb_data = 32'(i + 1);
            tick();
        end
        wb_en = 1'b0;
    endtask

    initial begin
        int low_cnt;
        int pulse_cnt;

        n_checks = 0; n_fail = 0;
        rst = 1'b0;
        rd_addr = {4'd15, 4'd5, 4'd3}; wb_en = 0; wb_addr = 0; wb_data = 0;
        iss_en = 0; iss_addr = 0; clr_req = 0;
        nb_rd_addr = {4'd3, 4'd3, 4'd3, 4'd3}; nb_wb_en = 0; nb_wb_addr = 0;
        nb_wb_data = 0; nb_iss_en = 0; nb_iss_addr = 0; nb_clr_req = 0;

        vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0, {4'd1, 4'd0, 4'd3},
                     {32'h0, 32'h0, 32'hDEADBEEF}, 3'b000};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd5, {4'd3, 4'd5, 4'd3},
                     {32'hDEADBEEF, 32'h0, 32'hDEADBEEF}, 3'b000};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, {4'd4, 4'd3, 4'd5},
                     {32'h0, 32'hDEADBEEF, 32'h0}, 3'b001};
        vecs[3]  = '{1'b1, 4'd5,  32'h11,       1'b1, 4'd5, {4'd0, 4'd5, 4'd5},
                     {32'h0, 32'h11, 32'h11}, 3'b000};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, {4'd15, 4'd2, 4'd5},
                     {32'h0, 32'h0, 32'h11}, 3'b001};
        vecs[5]  = '{1'b1, 4'd5,  32'h22,       1'b0, 4'd0, {4'd7, 4'd7, 4'd5},
                     {32'h0, 32'h0, 32'h22}, 3'b000};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, {4'd5, 4'd5, 4'd5},
                     {32'h22, 32'h22, 32'h22}, 3'b000};
        vecs[7]  = '{1'b1, 4'd15, 32'hCAFEF00D, 1'b1, 4'd0, {4'd14, 4'd0, 4'd15},
                     {32'h0, 32'h0, 32'hCAFEF00D}, 3'b000};
        vecs[8]  = '{1'b1, 4'd0,  32'h1234,     1'b0, 4'd0, {4'd0, 4'd15, 4'd0},
                     {32'h1234, 32'hCAFEF00D, 32'h1234}, 3'b000};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, {4'd3, 4'd15, 4'd0},
                     {32'hDEADBEEF, 32'hCAFEF00D, 32'h1234}, 3'b000};
        vecs[10] = '{1'b1, 4'd1,  32'hA5A5,     1'b1, 4'd2, {4'd9, 4'd1, 4'd2},
                     {32'h0, 32'hA5A5, 32'h0}, 3'b000};
        vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, {4'd9, 4'd1, 4'd2},
                     {32'h0, 32'hA5A5, 32'h0}, 3'b001};

        // Reset pulse straddling a clock edge
        #2 rst = 1'b1;
        #6 rst = 1'b0;
        tick();
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_clr_done", 128'(clr_done), 128'd0);
        chk("rst_rd_data", 128'(rd_data), 128'd0);
        chk("rst_rd_busy", 128'(rd_busy), 128'd0);
        chk("rst_nb_rd_data", nb_rd_data, 128'd0);
        chk("rst_nb_ready", 128'(nb_ready), 128'd1);

        // Table-driven bypass / scoreboard vectors (checked before the edge)
        for (int v = 0; v < 12; v++) begin
            wb_en = vecs[v].wb_en; wb_addr = vecs[v].wb_addr; wb_data = vecs[v].wb_data;
            iss_en = vecs[v].iss_en; iss_addr = vecs[v].iss_addr; rd_addr = vecs[v].rd_addr;
            #1;
            chk($sformatf("vec%0d_data", v), 128'(rd_data), 128'(vecs[v].exp_data));
            chk($sformatf("vec%0d_busy", v), 128'(rd_busy), 128'(vecs[v].exp_busy));
            tick();
        end
        wb_en = 1'b0; iss_en = 1'b0;

        // No-bypass build: write visible only after the edge, same data on all 4 ports
        nb_wb_en = 1'b1; nb_wb_addr = 4'd3; nb_wb_data = 32'hDEADBEEF;
        nb_rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
        #1;
        chk("nb_no_bypass", nb_rd_data, 128'd0);
        tick();
        nb_wb_en = 1'b0;
        #1;
        chk("nb_same_addr_4ports", nb_rd_data, {4{32'hDEADBEEF}});
        nb_wb_en = 1'b1; nb_wb_addr = 4'd14; nb_wb_data = 32'h77;
        nb_iss_en = 1'b1; nb_iss_addr = 4'd14;
        nb_rd_addr = {4'd14, 4'd14, 4'd14, 4'd14};
        tick();
        nb_wb_en = 1'b1; nb_wb_addr = 4'd11; nb_wb_data = 32'h99; nb_iss_en = 1'b0;
        #1;
        chk("nb_oob_read", nb_rd_data, 128'd0);
        chk("nb_oob_busy", 128'(nb_rd_busy), 128'd0);
        tick();
        nb_wb_en = 1'b0; nb_rd_addr = {4'd14, 4'd3, 4'd14, 4'd11};
        #1;
        chk("nb_last_reg", nb_rd_data, {32'h0, 32'hDEADBEEF, 32'h0, 32'h99});
        nb_iss_en = 1'b1; nb_iss_addr = 4'd5;
        tick();
        nb_iss_en = 1'b0;
        nb_wb_en = 1'b1; nb_wb_addr = 4'd5; nb_wb_data = 32'h5; nb_rd_addr = {4{4'd5}};
        #1;
        chk("nb_busy_unmasked", 128'(nb_rd_busy), 128'hF);
        tick();
        nb_wb_en = 1'b0;
        #1;
        chk("nb_busy_cleared", 128'(nb_rd_busy), 128'h0);

        // Soft clear with ignored write/issue/clr_req while busy
        fill_all();
        iss_en = 1'b1; iss_addr = 4'd9;
        tick();
        iss_en = 1'b0; rd_addr = {4'd0, 4'd0, 4'd9};
        #1;
        chk("pre_clr_busy9", 128'(rd_busy[0]), 128'd1);
        clr_req = 1'b1; rd_addr = {4'd15, 4'd2, 4'd0};
        tick();
        clr_req = 1'b0;
        low_cnt = 0; pulse_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (ready) break;
            low_cnt++;
            if (clr_done) begin
                pulse_cnt++;
                chk("clr_done_cycle", 128'(k), 128'd16);
            end
            if (k == 0) begin
                wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h55;
                iss_en = 1'b1; iss_addr = 4'd4; clr_req = 1'b1;
                #1;
                chk("mid_clr_contents", 128'(rd_data), {32'd16, 32'd3, 32'd1});
            end
            tick();
        end
        wb_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
        chk("clr_ready_low_cycles", 128'(low_cnt), 128'd17);
        chk("clr_done_pulses", 128'(pulse_cnt), 128'd1);
        for (int j = 0; j < 16; j++) begin
            rd_addr = {4'd0, 4'd0, 4'(j)};
            #1;
            chk($sformatf("post_clr_r%0d", j), 128'(rd_data[31:0]), 128'd0);
            chk($sformatf("post_clr_busy%0d", j), 128'(rd_busy[0]), 128'd0);
        end

        // Reset in the middle of a clear (idx == 7)
        fill_all();
        iss_en = 1'b1; iss_addr = 4'd3;
        tick();
        iss_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rd_addr = {4'd8, 4'd7, 4'd6};
        #1;
        chk("partial_clear", 128'(rd_data), {32'd9, 32'd8, 32'd0});
        chk("partial_ready", 128'(ready), 128'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ready", 128'(ready), 128'd1);
        chk("rst_mid_done", 128'(clr_done), 128'd0);
        chk("rst_mid_data", 128'(rd_data), 128'd0);
        rd_addr = {4'd12, 4'd15, 4'd3};
        #1;
        chk("rst_mid_data2", 128'(rd_data), 128'd0);
        chk("rst_mid_busy", 128'(rd_busy), 128'd0);
        #2 rst = 1'b0;
        low_cnt = 0; pulse_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!ready) low_cnt++;
            if (clr_done) pulse_cnt++;
        end
        chk("post_rst_no_pulse", 128'(pulse_cnt), 128'd0);
        chk("post_rst_ready", 128'(low_cnt), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
